// File: rtl/mem_initiator.sv
// Memory-bus initiator: arbitrates fetch vs load/store and runs one memory access at a time (build option ROUND_ROBIN_EN).
// Latency: read ack 3 cycles after the sampling edge, write ack 2 cycles; all outputs registered.
// Backpressure: requests are level-held until ack; new requests are only sampled in IDLE.
module mem_initiator #(
    parameter int adressBusWidth   = 12,
    parameter int instructionWidth = 32
) (
    input  logic                        clk,
    input  logic                        clear_n,
    input  logic                        f_req,
    input  logic [adressBusWidth-1:0]   f_addr,
    output logic                        f_ack,
    input  logic                        d_req,
    input  logic                        d_we,
    input  logic [adressBusWidth-1:0]   d_addr,
    input  logic [instructionWidth-1:0] d_wdata,
    output logic                        d_ack,
    output logic [instructionWidth-1:0] rdata,
    output logic                        busy,
    output logic                        memRead,
    output logic                        memWrite,
    output logic [adressBusWidth-1:0]   address,
    output logic [instructionWidth-1:0] writeData,
    input  logic [instructionWidth-1:0] memData
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RD_CAP = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t                      state_q, state_d;
    logic                        grant_q, grant_d;
    logic                        last_grant_q, last_grant_d;
    logic                        mem_read_q, mem_read_d;
    logic                        mem_write_q, mem_write_d;
    logic [adressBusWidth-1:0]   addr_q, addr_d;
    logic [instructionWidth-1:0] wdata_q, wdata_d;
    logic [instructionWidth-1:0] rdata_q, rdata_d;
    logic                        f_ack_q, f_ack_d;
    logic                        d_ack_q, d_ack_d;
    logic                        busy_q, busy_d;
    logic                        pick_data;

    always_comb begin
`ifdef ROUND_ROBIN_EN
        // On contention, serve whichever port did not win last time
        if (d_req && f_req) begin
            pick_data = (last_grant_q == PORT_F);
        end else begin
            pick_data = d_req;
        end
`else
        pick_data = d_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        f_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req || f_req) begin
                    if (pick_data) begin
                        grant_d = PORT_D;
                        addr_d  = d_addr;
                        if (d_we) begin
                            wdata_d     = d_wdata;
                            mem_write_d = 1'b1;
                            state_d     = WR;
                        end else begin
                            mem_read_d = 1'b1;
                            state_d    = RD;
                        end
                    end else begin
                        grant_d    = PORT_F;
                        addr_d     = f_addr;
                        mem_read_d = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            RD: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                // Memory registered its output at the end of RD; it is valid now
                rdata_d = memData;
                f_ack_d = (grant_q == PORT_F);
                d_ack_d = (grant_q == PORT_D);
                state_d = RESP;
            end
            WR: begin
                f_ack_d = (grant_q == PORT_F);
                d_ack_d = (grant_q == PORT_D);
                state_d = RESP;
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            grant_q      <= PORT_F;
            last_grant_q <= PORT_F;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            f_ack_q      <= f_ack_d;
            d_ack_q      <= d_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign memRead   = mem_read_q;
    assign memWrite  = mem_write_q;
    assign address   = addr_q;
    assign writeData = wdata_q;
    assign rdata     = rdata_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: unified memory model, arbitration-aware reference model and ack scoreboard.
module tb_mem_initiator;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          f_req, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          f_ack, d_ack, busy, memRead, memWrite;
    logic [DW-1:0] rdata, writeData, memData;
    logic [AW-1:0] address;

    always #5 clk = ~clk;

    mem_initiator #(.adressBusWidth(AW), .instructionWidth(DW)) dut (
        .clk(clk), .clear_n(clear_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .busy(busy),
        .memRead(memRead), .memWrite(memWrite), .address(address), .writeData(writeData),
        .memData(memData)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        if (a == 12'h400) return 32'hA840_0010;
        if (a[3:0] == 4'h0) return {24'h0, a[11:4]};
        return {8'h5A, a, a};
    endfunction

    // Unified memory with registered dataOutput
    logic [31:0] mem [0:4095];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] = init_val(12'(i));
            mem_ready = 1'b1;
        end
        if (memRead) memData <= mem[address];
        if (memWrite) mem[address] = writeData;
    end

    // Reference model: what memory holds, what rdata should show, who was last served
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;
    bit          last_port;

    function automatic logic [31:0] ref_rd(input logic [11:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit port, input bit we, input logic [11:0] a, input logic [31:0] wd);
        exp_t e;
        if (we) ref_mem[int'(a)] = wd;
        else last_rd = ref_rd(a);
        e.port  = port;
        e.rdata = last_rd;
        sb_q.push_back(e);
        last_port = port;
    endtask

    // Bus/ack monitor
    typedef struct {
        int          c;
        logic [11:0] a;
    } rd_ev_t;
    rd_ev_t rd_log[$];
    rd_ev_t ev;
    int     cyc = 0;
    bit     prev_rd = 1'b0, prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clear_n) begin
            checks++;
            if (memRead && memWrite) begin
                errors++;
                $display("FAIL bus_excl: memRead=%b memWrite=%b required not both", memRead, memWrite);
            end
            if (memRead && prev_rd) begin
                errors++;
                $display("FAIL rd_pulse: memRead high %0d cycles required 1", 2);
            end
            if (memWrite && prev_wr) begin
                errors++;
                $display("FAIL wr_pulse: memWrite high %0d cycles required 1", 2);
            end
            if (memRead) begin
                ev.c = cyc;
                ev.a = address;
                rd_log.push_back(ev);
            end
            prev_rd = memRead;
            prev_wr = memWrite;
            if (f_ack || d_ack) begin
                if (f_ack && d_ack) begin
                    errors++;
                    $display("FAIL both_ack: f_ack=1 d_ack=1 required one");
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: f_ack=%b d_ack=%b required none", f_ack, d_ack);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ack_port", 32'(d_ack), 32'(mon_e.port));
                    chk("ack_rdata", rdata, mon_e.rdata);
                end
            end
        end else begin
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end
    end

    task automatic check_zero(input string name);
        chk({name, " memRead"}, 32'(memRead), 0);
        chk({name, " memWrite"}, 32'(memWrite), 0);
        chk({name, " address"}, 32'(address), 0);
        chk({name, " writeData"}, writeData, 0);
        chk({name, " rdata"}, rdata, 0);
        chk({name, " f_ack"}, 32'(f_ack), 0);
        chk({name, " d_ack"}, 32'(d_ack), 0);
        chk({name, " busy"}, 32'(busy), 0);
    endtask

    // Starts at the negedge before the sampling edge; returns at the negedge showing the ack
    task automatic wait_ack(input bit port, input bit we, input logic [11:0] a,
                            input logic [31:0] wd, input string name);
        int lat, n, busy_n;
        bit got;
        lat = we ? 2 : 3;
        n = 0;
        busy_n = 0;
        got = 1'b0;
        @(posedge clk);
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (n == 1) chk({name, " strobe"}, 32'(we ? memWrite : memRead), 1);
            chk({name, " address"}, 32'(address), 32'(a));
            if (we) chk({name, " writeData"}, writeData, wd);
            got = port ? d_ack : f_ack;
        end
        chk({name, " latency"}, 32'(n), 32'(lat));
        chk({name, " busy cycles"}, 32'(busy_n), 32'(lat));
    endtask

    task automatic access(input bit port, input bit we, input logic [11:0] a,
                          input logic [31:0] wd, input bit hold, input string name);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            f_req = 1'b1; f_addr = a;
        end
        push_exp(port, port ? we : 1'b0, a, wd);
        wait_ack(port, port ? we : 1'b0, a, wd, name);
        if (!hold) begin
            if (port) d_req = 1'b0;
            else f_req = 1'b0;
        end
        @(negedge clk);
        chk({name, " idle busy"}, 32'(busy), 0);
    endtask

    logic [11:0] cd_q[$];
    logic [11:0] cf_q[$];

    // Both ports hold their requests high until their own address lists drain
    task automatic contention(input string name);
        bit          win;
        int          guard;
        logic [11:0] a;
        guard = 0;
        if (cd_q.size() > 0) begin d_req = 1'b1; d_we = 1'b0; d_addr = cd_q[0]; end
        if (cf_q.size() > 0) begin f_req = 1'b1; f_addr = cf_q[0]; end
        while ((cd_q.size() > 0 || cf_q.size() > 0) && guard < 20) begin
            guard++;
            if (cd_q.size() > 0 && cf_q.size() > 0) begin
`ifdef ROUND_ROBIN_EN
                win = (last_port == 1'b0);
`else
                win = 1'b1;
`endif
            end else begin
                win = (cd_q.size() > 0);
            end
            a = win ? cd_q[0] : cf_q[0];
            push_exp(win, 1'b0, a, 0);
            wait_ack(win, 1'b0, a, 0, name);
            if (win) begin
                void'(cd_q.pop_front());
                if (cd_q.size() > 0) d_addr = cd_q[0];
                else d_req = 1'b0;
            end else begin
                void'(cf_q.pop_front());
                if (cf_q.size() > 0) f_addr = cf_q[0];
                else f_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        clear_n = 1'b1;
        f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
        last_rd = 0; last_port = 1'b0;
        #1 clear_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        clear_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a write, between clock edges
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h055; d_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        chk("t1 write active", 32'(memWrite), 1);
        #2 clear_n = 1'b0;
        #1 check_zero("t1 async");
        d_req = 1'b0;
        last_rd = 0; last_port = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);

        access(1'b0, 1'b0, 12'h400, 0, 1'b0, "t2 fetch");
        access(1'b1, 1'b1, 12'h030, 32'h3, 1'b0, "t3 write");
        access(1'b1, 1'b0, 12'h030, 0, 1'b0, "t3 read");
        access(1'b1, 1'b0, 12'h055, 0, 1'b0, "t1 abandoned write");

        // Reset during RD_CAP: access abandoned, then re-served as a new request
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        chk("t5 rdata", rdata, 0);
        chk("t5 d_ack", 32'(d_ack), 0);
        chk("t5 memRead", 32'(memRead), 0);
        chk("t5 busy", 32'(busy), 0);
        last_rd = 0; last_port = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        push_exp(1'b1, 1'b0, 12'h020, 0);
        wait_ack(1'b1, 1'b0, 12'h020, 0, "t5 retry");
        d_req = 1'b0;
        @(negedge clk);

        cd_q = '{12'h010};
        cf_q = '{12'h401};
        contention("t4 pair");
        cd_q = '{12'h010, 12'h020, 12'h010, 12'h020};
        cf_q = '{12'h401, 12'h402};
        contention("t4 long");

        rd_log.delete();
        for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 12'h400 + 12'(i), 0, (i < 3), "t6 fetch");
        chk("t6 pulses", 32'(rd_log.size()), 4);
        for (int i = 0; i < rd_log.size() && i < 4; i++) begin
            chk("t6 addr", 32'(rd_log[i].a), 32'(12'h400 + 12'(i)));
            if (i > 0) chk("t6 spacing", 32'(rd_log[i].c - rd_log[i-1].c), 4);
        end

        for (int i = 0; i < 40; i++) begin
            bit          p, w;
            logic [11:0] a;
            p = 1'($urandom_range(0, 1));
            w = p ? 1'($urandom_range(0, 1)) : 1'b0;
            a = 12'h0C0 + 12'($urandom_range(0, 7));
            access(p, w, a, $urandom, 1'b0, "rand");
        end

        @(negedge clk);
        chk("scoreboard drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
